// File: rtl/s38584_pkg.sv
// Shared definitions for the s38584 state stages: bit indices, default widths, mode encoding.
package s38584_pkg;

    localparam int unsigned IDX_G2070 = 0;
    localparam int unsigned IDX_G2084 = 1;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_CAP  = 2'd1,
        MODE_SCAN = 2'd2
    } mode_t;

endpackage

// File: rtl/s38584_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment, never wraps.
module s38584_sat_counter
    import s38584_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sat = &r_cnt;
    assign cnt = r_cnt;

endmodule

// File: rtl/s38584_g2070_state_stage.sv
// g2070/g2084 state register bank with functional capture, scan shift and transition counting.
module s38584_g2070_state_stage
    import s38584_pkg::*;
#(
    parameter int unsigned   W       = DEF_W,
    parameter int unsigned   CNT_W   = DEF_CNT_W,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     nxt,
    input  logic             scan_en,
    input  logic             scan_in,
    input  logic             cnt_clr,
    output logic [W-1:0]     state,
    output logic             scan_out,
    output logic             toggled,
    output logic [CNT_W-1:0] trans_cnt,
    output logic             cnt_sat
);

    logic [W-1:0] r_state;
    logic         r_toggled;

    mode_t        w_mode;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_state_nxt;
    logic         w_toggled_nxt;
    logic         w_inc;

    // Mode decode and next-state; nxt only matters in capture mode.
    always_comb begin
        w_mode        = MODE_HOLD;
        w_diff        = '0;
        w_state_nxt   = r_state;
        w_toggled_nxt = 1'b0;
        w_inc         = 1'b0;
        if (scan_en) begin
            w_mode = MODE_SCAN;
        end else if (en) begin
            w_mode = MODE_CAP;
        end
        unique case (w_mode)
            MODE_SCAN: begin
                w_state_nxt = {r_state[W-2:0], scan_in};
            end
            MODE_CAP: begin
                w_diff        = nxt ^ r_state;
                w_state_nxt   = nxt;
                w_toggled_nxt = |w_diff;
                w_inc         = |w_diff;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RST_VAL;
            r_toggled <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_toggled <= w_toggled_nxt;
        end
    end

    s38584_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc),
        .clr (cnt_clr),
        .cnt (trans_cnt),
        .sat (cnt_sat)
    );

    assign state    = r_state;
    assign toggled  = r_toggled;
    assign scan_out = r_state[W-1];

endmodule

// File: tb/tb_s38584_g2070_state_stage.sv
// Self-checking bench for s38584_g2070_state_stage: table vectors, model scoreboard, corner sequences.
module tb_s38584_g2070_state_stage;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [W-1:0]     nxt;
    logic             scan_en;
    logic             scan_in;
    logic             cnt_clr;
    logic [W-1:0]     state;
    logic             scan_out;
    logic             toggled;
    logic [CNT_W-1:0] trans_cnt;
    logic             cnt_sat;

    s38584_g2070_state_stage #(
        .W       (W),
        .CNT_W   (CNT_W),
        .RST_VAL ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .nxt       (nxt),
        .scan_en   (scan_en),
        .scan_in   (scan_in),
        .cnt_clr   (cnt_clr),
        .state     (state),
        .scan_out  (scan_out),
        .toggled   (toggled),
        .trans_cnt (trans_cnt),
        .cnt_sat   (cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     st;
        logic             tog;
        logic [CNT_W-1:0] cnt;
        logic             sat;
        logic             so;
    } exp_t;

    typedef struct {
        logic             en;
        logic             scan_en;
        logic             scan_in;
        logic             cnt_clr;
        logic [W-1:0]     nxt;
        logic [W-1:0]     st;
        logic             tog;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0]     m_st;
    logic             m_tog;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model of one clock edge.
    task automatic model_step(input logic r, input logic e, input logic se, input logic si,
                              input logic cc, input logic [W-1:0] n);
        logic [W-1:0] d;
        if (r) begin
            m_st = '0; m_tog = 1'b0; m_cnt = '0;
        end else if (se) begin
            m_st  = {m_st[W-2:0], si};
            m_tog = 1'b0;
            if (cc) m_cnt = '0;
        end else if (e) begin
            d     = n ^ m_st;
            m_tog = |d;
            if (cc) m_cnt = '0;
            else if ((|d) && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
            m_st  = n;
        end else begin
            m_tog = 1'b0;
            if (cc) m_cnt = '0;
        end
    endtask

    // Drive one cycle, push expectation, compare after the edge.
    task automatic cyc(input logic r, input logic e, input logic se, input logic si,
                       input logic cc, input logic [W-1:0] n,
                       input bit use_tab, input exp_t tab_e);
        exp_t ex;
        rst = r; en = e; scan_en = se; scan_in = si; cnt_clr = cc; nxt = n;
        model_step(r, e, se, si, cc, n);
        if (use_tab) ex = tab_e;
        else begin
            ex.st = m_st; ex.tog = m_tog; ex.cnt = m_cnt;
            ex.sat = (m_cnt == {CNT_W{1'b1}}); ex.so = m_st[W-1];
        end
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            ex = exp_q.pop_front();
            chk("state",     32'(state),     32'(ex.st));
            chk("toggled",   32'(toggled),   32'(ex.tog));
            chk("trans_cnt", 32'(trans_cnt), 32'(ex.cnt));
            chk("cnt_sat",   32'(cnt_sat),   32'(ex.sat));
            chk("scan_out",  32'(scan_out),  32'(ex.so));
        end
        @(negedge clk);
    endtask

    task automatic mcyc(input logic r, input logic e, input logic se, input logic si,
                        input logic cc, input logic [W-1:0] n);
        exp_t dummy;
        dummy = '{default: '0};
        cyc(r, e, se, si, cc, n, 1'b0, dummy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tab[8];
        exp_t          te;
        logic [W-1:0]  held;
        logic [CNT_W-1:0] held_cnt;
        logic [7:0]    scan_bits;

        rst = 1'b1; en = 1'b0; scan_en = 1'b0; scan_in = 1'b0; cnt_clr = 1'b0; nxt = '0;
        m_st = '0; m_tog = 1'b0; m_cnt = '0;
        @(negedge clk);

        // Reset with active capture inputs.
        mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("reset_state", 32'(state), 32'h0);
        chk("reset_cnt",   32'(trans_cnt), 32'h0);

        // Capture / hold vectors with literal expectations.
        tab[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b1, 4'd1};
        tab[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 4'd1};
        tab[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 8'h03, 1'b1, 4'd2};
        tab[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h03, 1'b0, 4'd2};
        tab[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h03, 1'b0, 4'd2};
        tab[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h82, 8'h82, 1'b1, 4'd3};
        tab[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 4'd0};
        tab[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 4'd0};
        for (int i = 0; i < 8; i++) begin
            te.st = tab[i].st; te.tog = tab[i].tog; te.cnt = tab[i].cnt;
            te.sat = (tab[i].cnt == {CNT_W{1'b1}}); te.so = tab[i].st[W-1];
            cyc(1'b0, tab[i].en, tab[i].scan_en, tab[i].scan_in, tab[i].cnt_clr,
                tab[i].nxt, 1'b1, te);
        end

        // Hold with random nxt: nothing moves.
        held = state; held_cnt = trans_cnt;
        for (int i = 0; i < 5; i++) mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom));
        chk("hold_state", 32'(state), 32'(held));
        chk("hold_cnt",   32'(trans_cnt), 32'(held_cnt));

        // Scan shift from zero with en high and random nxt.
        mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        held_cnt = trans_cnt;
        scan_bits = 8'b10110010;
        for (int i = 7; i >= 0; i--) mcyc(1'b0, 1'b1, 1'b1, scan_bits[i], 1'b0, W'($urandom));
        chk("scan_state", 32'(state), 32'hB2);
        chk("scan_out_8th", 32'(scan_out), 32'h1);
        chk("scan_cnt", 32'(trans_cnt), 32'(held_cnt));

        // Saturation: alternate captures until the counter pins.
        mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 20; i++) mcyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i % 2 == 0) ? 8'h00 : 8'h01);
        chk("sat_cnt", 32'(trans_cnt), 32'd15);
        chk("sat_flag", 32'(cnt_sat), 32'd1);
        mcyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ~state);
        chk("clr_wins_cnt", 32'(trans_cnt), 32'd0);
        chk("clr_toggled",  32'(toggled), 32'd1);

        // Reset on the third shift cycle, then resume shifting.
        mcyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        mcyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        mcyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("midscan_rst", 32'(state), 32'h0);
        mcyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        mcyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        chk("resume_shift", 32'(state), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s38584_g2070_state_stage.md
Name: s38584_g2070_state_stage

Overview:
- Sequential stage directly downstream of the n7417 next-state cone. Holds the g2070/g2084 state bits plus a parameterised bank of neighbouring state bits.
- Captures the combinational next-state values under the functional clock enable (the g35 role).
- Provides a scan shift path and counts state transitions for bring-up and debug.
- Outputs feed back into the next-state cones as their present-state inputs.

Parameters:
- W, 8, total state bits held; bit 0 = g2070, bit 1 = g2084, bits 2..W-1 = neighbouring cone bits; W >= 2.
- CNT_W, 16, width of the transition counter.
- RST_VAL, all zeros, W-bit reset value of the state register.

Ports:
- clk  in  1  functional clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  functional capture enable (g35 role).
- nxt  in  W  next-state vector from upstream cones; nxt[0] = n7417.
- scan_en  in  1  scan shift mode; overrides en.
- scan_in  in  1  serial scan input.
- cnt_clr  in  1  synchronous clear of the transition counter.
- state  out  W  registered present state; state[0] = g2070, state[1] = g2084.
- scan_out  out  1  equals state[W-1].
- toggled  out  1  registered; 1 for one cycle after any captured bit changed value.
- trans_cnt  out  CNT_W  saturating count of functional capture cycles that changed state.
- cnt_sat  out  1  high while trans_cnt is all ones.

Behaviour:
- Reset, when rst=1 at a rising edge:
  - state=RST_VAL, toggled=0, trans_cnt=0, cnt_sat=0.
  - rst has priority over scan_en, en and cnt_clr.
- Mode priority per cycle: rst > scan_en > en > hold.
- Scan shift (scan_en=1):
  - state <= {state[W-2:0], scan_in}.
  - toggled forced to 0 next cycle; trans_cnt unchanged.
  - scan_out is valid the same cycle it reflects state[W-1], i.e. one bit per clock, zero added latency.
- Functional capture (scan_en=0, en=1):
  - state <= nxt, one-cycle latency.
  - diff = nxt XOR state (pre-update value).
  - toggled <= |diff.
  - If |diff and trans_cnt is not all ones: trans_cnt increments by 1.
- Hold (scan_en=0, en=0): state unchanged; toggled <= 0.
- Counter:
  - Saturates at 2^CNT_W-1; never wraps.
  - cnt_sat is combinational from trans_cnt.
- cnt_clr=1:
  - trans_cnt <= 0 on that edge.
  - If a changing capture occurs in the same cycle, the clear wins and trans_cnt=0. toggled still updates normally.
- en toggling mid-scan has no effect; scan_en alone selects shift.
- Deassertion of rst: the first edge with rst=0 behaves normally.
- No X propagation from nxt while en=0 or scan_en=1; nxt is ignored in those cycles.
- No combinational path from any input to state, toggled or trans_cnt.

Decomposition:
- Shared package s38584_pkg holds:
  - localparam indices IDX_G2070=0, IDX_G2084=1.
  - Default W and CNT_W.
  - Enum for mode {MODE_HOLD, MODE_CAP, MODE_SCAN}.
- One natural sub-module: s38584_sat_counter, a CNT_W saturating counter with inc, clr and sat outputs, reused by sibling stages.
- The mode decode and state register stay in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles with en=1, nxt=8'hFF → state=8'h00, toggled=0, trans_cnt=0 after release.
- Capture and count: en=1, nxt sequence 8'h01, 8'h01, 8'h03 → state follows one cycle later; toggled pattern 1,0,1; trans_cnt=2.
- Hold: en=0, nxt random for 5 cycles → state stable, toggled=0, trans_cnt unchanged.
- Scan: scan_en=1, en=1, shift scan_in bits 1,0,1,1,0,0,1,0 from state=0 → state=8'b10110010 after 8 clocks; scan_out=1 observed on the 8th; trans_cnt unchanged.
- Saturation: CNT_W=4, 20 alternating captures of 8'h00/8'h01 → trans_cnt stops at 15 and cnt_sat=1. Then cnt_clr=1 together with a changing capture → trans_cnt=0 and toggled=1.
- Reset mid-scan: assert rst on the 3rd shift cycle with scan_en=1 → state=RST_VAL next edge. Shifting resumes from RST_VAL after rst drops.
